// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V decode constants and the immediate-select encoding
//   OPC_*      : major opcode field values (instr[6:0]) used for pre-decode
//   imm_sel_e  : immediate format select shared with the immediate generator
//   INSTR_NOP  : canonical NOP (addi x0, x0, 0)
package riscv_pkg;

    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_U = 2'd3
    } imm_sel_e;

endpackage

// File: rtl/imm_sel_decode.sv
// imm_sel_decode: combinational opcode -> immediate-select pre-decode
//   opcode  in  7  instr[6:0]
//   imm_sel out 2  immediate format; anything not S/B/U (including JAL) maps to IMM_I
module imm_sel_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_sel_e   imm_sel
);

    always_comb begin
        imm_sel = (opcode == OPC_STORE)                           ? IMM_S :
                  (opcode == OPC_BRANCH)                          ? IMM_B :
                  (opcode == OPC_LUI) || (opcode == OPC_AUIPC)    ? IMM_U : IMM_I;
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: fetch-to-decode instruction FIFO with immediate-select pre-decode
//   clk_i, rst_ni                       clock, async active-low reset
//   flush_i                             drop every queued entry and the word presented this cycle
//   imem_valid_i/pc_i/instr_i/ready_o   fetch side handshake (ready = not full, state only)
//   dec_valid_o/ready_i                 decode side handshake
//   dec_pc_o/instr_o/imm_sel_o          head entry; NOP / last-popped PC / IMM_I when empty
//   perf_bubbles_o                      only with FETCH_PERF_EN: cycles decode was ready but starved
// Optional feature macro: FETCH_PERF_EN
module fetch_decode_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_pc_i,
    input  logic [31:0] imem_instr_i,
    output logic        imem_ready_o,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_pc_o,
    output logic [31:0] dec_instr_o,
`ifdef FETCH_PERF_EN
    output logic [1:0]  dec_imm_sel_o,
    output logic [31:0] perf_bubbles_o
`else
    output logic [1:0]  dec_imm_sel_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    imm_sel_e    sel_mem   [DEPTH];

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] last_pc;
    logic        full, empty, push, pop;
    imm_sel_e    push_sel;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = imem_valid_i && !full && !flush_i;
    assign pop   = !empty && dec_ready_i && !flush_i;

    imm_sel_decode u_imm_sel_decode (
        .opcode  (imem_instr_i[6:0]),
        .imm_sel (push_sel)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            last_pc <= RESET_PC;
        end else if (flush_i) begin
            rd_ptr  <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                last_pc <= pc_mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Payload storage needs no reset: it is only observed through the non-empty mux below.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr[AW-1:0]]    <= imem_pc_i;
            instr_mem[wr_ptr[AW-1:0]] <= imem_instr_i;
            sel_mem[wr_ptr[AW-1:0]]   <= push_sel;
        end
    end

    always_comb begin
        imem_ready_o  = !full;
        dec_valid_o   = !empty;
        dec_pc_o      = empty ? last_pc   : pc_mem[rd_ptr[AW-1:0]];
        dec_instr_o   = empty ? INSTR_NOP : instr_mem[rd_ptr[AW-1:0]];
        dec_imm_sel_o = empty ? IMM_I     : sel_mem[rd_ptr[AW-1:0]];
    end

`ifdef FETCH_PERF_EN
    // Flush does not clear this; only reset does.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_bubbles_o <= '0;
        else if (dec_ready_i && empty) perf_bubbles_o <= perf_bubbles_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed vector table, directed corner sequences and randomized model-checked traffic
module tb_fetch_decode_queue;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_2000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_ni, flush_i, imem_valid_i, imem_ready_o, dec_valid_o, dec_ready_i;
    logic [31:0] imem_pc_i, imem_instr_i, dec_pc_o, dec_instr_o;
    logic [1:0]  dec_imm_sel_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubbles_o;
`endif

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .imem_valid_i  (imem_valid_i),
        .imem_pc_i     (imem_pc_i),
        .imem_instr_i  (imem_instr_i),
        .imem_ready_o  (imem_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o),
`ifdef FETCH_PERF_EN
        .dec_imm_sel_o (dec_imm_sel_o),
        .perf_bubbles_o(perf_bubbles_o)
`else
        .dec_imm_sel_o (dec_imm_sel_o)
`endif
    );

    typedef struct {
        logic        flush, iv, dr;
        logic [31:0] pc, instr;
        logic        ev, er;
        logic [31:0] epc, einstr;
        logic [1:0]  esel;
    } vec_t;

    typedef struct {
        logic [31:0] pc, instr;
    } ent_t;

    vec_t        vecs[12];
    ent_t        q[$];
    logic [31:0] m_last_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sel_of(input logic [31:0] ins);
        case (ins[6:0])
            7'b0100011:             return 2'd1;
            7'b1100011:             return 2'd2;
            7'b0110111, 7'b0010111: return 2'd3;
            default:                return 2'd0;
        endcase
    endfunction

    task automatic model_check(input string tag);
        bit v;
        v = (q.size() > 0);
        chk({tag, ".valid"}, dec_valid_o, v);
        chk({tag, ".ready"}, imem_ready_o, q.size() < DEPTH);
        chk({tag, ".pc"}, dec_pc_o, v ? q[0].pc : m_last_pc);
        chk({tag, ".instr"}, dec_instr_o, v ? q[0].instr : NOP);
        chk({tag, ".sel"}, dec_imm_sel_o, v ? sel_of(q[0].instr) : 2'd0);
    endtask

    // Check current outputs against the model, apply one cycle of inputs, then advance the model.
    task automatic cycle(input string tag, input logic f, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic dr);
        bit do_push, do_pop;
        ent_t e;
        model_check(tag);
        flush_i = f; imem_valid_i = iv; imem_pc_i = pc; imem_instr_i = ins; dec_ready_i = dr;
        do_push = iv && (q.size() < DEPTH);
        do_pop  = dr && (q.size() > 0);
        @(posedge clk); #1;
        if (f) q.delete();
        else begin
            if (do_pop) begin
                m_last_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (do_push) begin
                e.pc = pc; e.instr = ins;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle_inputs();
        flush_i = 0; imem_valid_i = 0; imem_pc_i = 0; imem_instr_i = 0; dec_ready_i = 0;
    endtask

    initial begin
        //           flush iv dr  pc            instr          ev er epc           einstr         esel
        vecs[0]  = '{0, 1, 0, 32'h2000, 32'h00A12223, 1, 1, 32'h2000, 32'h00A12223, 2'd1};
        vecs[1]  = '{0, 1, 0, 32'h2004, 32'h00B50463, 1, 0, 32'h2000, 32'h00A12223, 2'd1};
        vecs[2]  = '{0, 1, 0, 32'h2008, 32'h00000013, 1, 0, 32'h2000, 32'h00A12223, 2'd1};
        vecs[3]  = '{0, 0, 1, 32'h0,    32'h0,        1, 1, 32'h2004, 32'h00B50463, 2'd2};
        vecs[4]  = '{0, 0, 1, 32'h0,    32'h0,        0, 1, 32'h2004, NOP,          2'd0};
        vecs[5]  = '{0, 1, 0, 32'h3000, 32'h00000013, 1, 1, 32'h3000, 32'h00000013, 2'd0};
        vecs[6]  = '{0, 1, 0, 32'h3004, 32'h00100093, 1, 0, 32'h3000, 32'h00000013, 2'd0};
        vecs[7]  = '{1, 1, 0, 32'h3008, 32'h00000297, 0, 1, 32'h2004, NOP,          2'd0};
        vecs[8]  = '{0, 0, 1, 32'h0,    32'h0,        0, 1, 32'h2004, NOP,          2'd0};
        vecs[9]  = '{0, 1, 1, 32'h4000, 32'h123450B7, 1, 1, 32'h4000, 32'h123450B7, 2'd3};
        vecs[10] = '{0, 1, 1, 32'h4004, 32'h00000297, 1, 1, 32'h4004, 32'h00000297, 2'd3};
        vecs[11] = '{0, 0, 1, 32'h0,    32'h0,        0, 1, 32'h4004, NOP,          2'd0};

        idle_inputs();
        rst_ni = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", dec_valid_o, 1'b0);
        chk("reset.ready", imem_ready_o, 1'b1);
        chk("reset.instr", dec_instr_o, NOP);
        chk("reset.pc", dec_pc_o, RST_PC);
        chk("reset.sel", dec_imm_sel_o, 2'd0);
        rst_ni = 1;

        foreach (vecs[i]) begin
            flush_i = vecs[i].flush; imem_valid_i = vecs[i].iv; dec_ready_i = vecs[i].dr;
            imem_pc_i = vecs[i].pc; imem_instr_i = vecs[i].instr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.valid", i), dec_valid_o, vecs[i].ev);
            chk($sformatf("vec%0d.ready", i), imem_ready_o, vecs[i].er);
            chk($sformatf("vec%0d.pc", i), dec_pc_o, vecs[i].epc);
            chk($sformatf("vec%0d.instr", i), dec_instr_o, vecs[i].einstr);
            chk($sformatf("vec%0d.sel", i), dec_imm_sel_o, vecs[i].esel);
        end

        q.delete();
        m_last_pc = 32'h4004;

        for (int i = 0; i < 20; i++)
            cycle("stream", 0, 1, 32'h5000 + 32'(4 * i), (i % 2 == 0) ? 32'h123450B7 : 32'h00100093, 1);
        for (int i = 0; i < 3; i++) cycle("stream_tail", 0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic [6:0]  opc;
            case ($urandom_range(0, 5))
                0: opc = 7'b0100011;
                1: opc = 7'b1100011;
                2: opc = 7'b0110111;
                3: opc = 7'b0010111;
                4: opc = 7'b1101111;
                default: opc = 7'($urandom);
            endcase
            ins = {$urandom} & 32'hFFFF_FF80 | {25'd0, opc};
            cycle("rand", $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, $urandom, ins,
                  $urandom_range(0, 2) != 0);
        end

        flush_i = 0; imem_valid_i = 1; imem_pc_i = 32'h6000; imem_instr_i = 32'h00A12223; dec_ready_i = 0;
        @(posedge clk); #2;
        rst_ni = 0;
        #1;
        chk("midreset.valid", dec_valid_o, 1'b0);
        chk("midreset.ready", imem_ready_o, 1'b1);
        chk("midreset.pc", dec_pc_o, RST_PC);
        chk("midreset.instr", dec_instr_o, NOP);
        idle_inputs();
        @(posedge clk); #1;
        rst_ni = 1;
        q.delete();
        m_last_pc = RST_PC;
        cycle("post_reset", 0, 1, 32'h7000, 32'h00B50463, 0);
        cycle("post_reset", 0, 0, 0, 0, 1);
        model_check("post_reset_end");

`ifdef FETCH_PERF_EN
        idle_inputs();
        rst_ni = 0;
        @(posedge clk); #1;
        rst_ni = 1;
        dec_ready_i = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("perf.count", perf_bubbles_o, 32'd5);
        @(posedge clk); #2;
        rst_ni = 0;
        #1;
        chk("perf.reset", perf_bubbles_o, 32'd0);
        rst_ni = 1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
